// File: rtl/level_code_buffer.sv
// level_code_buffer
// Captures the non-trailing-one non-zero coefficients of one block in scan
// order. Each level is converted to its CAVLC levelCode as it is written.
// After the block ends, the stored codes are drained over a valid/ready stream.
module level_code_buffer #(
    parameter int COEFF_W = 8,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int LC_W    = COEFF_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      h264_reset,
    input  logic                      cnt_rst,
    input  logic                      start_cnt_i,
    input  logic                      coeff_valid_i,
    input  logic signed [COEFF_W-1:0] coeff_i,
    input  logic [1:0]                trailing_ones_cnt,
    input  logic                      trailing_ones_stop_cnt,
    input  logic                      blk_done_i,
    output logic [LC_W-1:0]           level_code_o,
    output logic                      level_valid_o,
    output logic                      level_last_o,
    input  logic                      level_ready_i,
    output logic [CNT_W-1:0]          level_code_cnt,
    output logic                      done_o,
    output logic                      ovf_o,
    output logic                      err_o
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [COEFF_W-1:0] COEFF_ZERO = {COEFF_W{1'b0}};
    localparam logic [COEFF_W-1:0] COEFF_P1   = {{(COEFF_W-1){1'b0}}, 1'b1};
    localparam logic [COEFF_W-1:0] COEFF_M1   = {COEFF_W{1'b1}};
    localparam logic [LC_W-1:0]    LC_ONE    = {{(LC_W-1){1'b0}}, 1'b1};
    localparam logic [LC_W-1:0]    LC_TWO    = {{(LC_W-2){1'b0}}, 2'b10};
    localparam logic [LC_W-1:0]    LC_ZERO   = {LC_W{1'b0}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // levelCode = 2L-2 for positive L, 2|L|-1 for negative L (L != 0).
    // Negation is done one bit wider than the coefficient so that the most
    // negative value still has a representable magnitude.
    function automatic logic [LC_W-1:0] level_code_f(input logic [COEFF_W-1:0] lvl);
        logic [LC_W-1:0] ext;
        logic [LC_W-1:0] mag;
        logic            neg;
        neg = lvl[COEFF_W-1];
        ext = {{(LC_W-COEFF_W){lvl[COEFF_W-1]}}, lvl};
        if (neg) begin
            mag = ~ext + LC_ONE;
            return (mag << 1'b1) - LC_ONE;
        end else begin
            mag = ext;
            return (mag << 1'b1) - LC_TWO;
        end
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   rd_ptr_r;
    logic [LC_W-1:0]    mem_r [DEPTH];
    logic               valid_r;
    logic               done_r;
    logic               ovf_r;
    logic               err_r;

    logic               clr_s;
    logic               wr_req_s;
    logic               full_s;
    logic               wr_take_s;
    logic               last_s;
    logic [LC_W-1:0]    raw_code_s;
    logic [LC_W-1:0]    wr_code_s;
    logic               err_set_s;
    logic               first_adj_s;
    logic               unit_s;

    // All three clears have identical effect, so they collapse into one term.
    assign clr_s     = rst | h264_reset | cnt_rst;
    assign wr_req_s  = (state_r == ST_COLLECT) & coeff_valid_i & start_cnt_i &
                       ((trailing_ones_cnt == 2'd3) | trailing_ones_stop_cnt) &
                       (coeff_i != COEFF_ZERO);
    assign full_s    = (cnt_r == CNT_FULL);
    assign wr_take_s = wr_req_s & ~full_s;
    assign last_s    = (rd_ptr_r == (cnt_r - CNT_ONE));

    // Convert the incoming level; first level of a block with <3 trailing
    // ones is lowered by 2 unless that would underflow (|L|==1).
    always_comb begin
        raw_code_s  = level_code_f(coeff_i);
        wr_code_s   = raw_code_s;
        err_set_s   = 1'b0;
        first_adj_s = (cnt_r == CNT_ZERO) && (trailing_ones_cnt != 2'd3);
        unit_s      = (coeff_i == COEFF_P1) || (coeff_i == COEFF_M1);
        if (first_adj_s && unit_s) begin
            err_set_s = wr_take_s;
        end else if (first_adj_s) begin
            wr_code_s = raw_code_s - LC_TWO;
        end else begin
            wr_code_s = raw_code_s;
        end
    end

    // Next-state selection for the collect/drain/done sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (blk_done_i) begin
                    // a write in the same cycle counts toward the block
                    state_next_s = ((cnt_r != CNT_ZERO) || wr_take_s) ? ST_DRAIN : ST_DONE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (level_ready_i && last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_COLLECT;
            end
            default: begin
                state_next_s = ST_COLLECT;
            end
        endcase
    end

    // State, storage, pointers and sticky flags.
    always_ff @(posedge clk) begin
        if (clr_s) begin
            state_r  <= ST_COLLECT;
            cnt_r    <= CNT_ZERO;
            rd_ptr_r <= CNT_ZERO;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= LC_ZERO;
            end
        end else begin
            state_r <= state_next_s;
            valid_r <= (state_next_s == ST_DRAIN);
            done_r  <= (state_next_s == ST_DONE);
            if (wr_take_s) begin
                mem_r[cnt_r[ADDR_W-1:0]] <= wr_code_s;
                cnt_r                    <= cnt_r + CNT_ONE;
            end
            if (wr_req_s && full_s) begin
                ovf_r <= 1'b1;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_COLLECT: begin
                    if (blk_done_i) begin
                        rd_ptr_r <= CNT_ZERO;
                    end
                end
                ST_DRAIN: begin
                    if (level_ready_i && !last_s) begin
                        rd_ptr_r <= rd_ptr_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    cnt_r    <= CNT_ZERO;
                    rd_ptr_r <= CNT_ZERO;
                end
                default: begin
                    rd_ptr_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign level_valid_o  = valid_r;
    assign level_code_o   = valid_r ? mem_r[rd_ptr_r[ADDR_W-1:0]] : LC_ZERO;
    assign level_last_o   = valid_r & last_s;
    assign level_code_cnt = cnt_r;
    assign done_o         = done_r;
    assign ovf_o          = ovf_r;
    assign err_o          = err_r;

endmodule

// File: tb/tb_level_code_buffer.sv
// Directed bench for level_code_buffer with a scoreboard queue of expected
// drain beats and a negedge monitor that checks each accepted beat.
module tb_level_code_buffer;

    localparam int COEFF_W = 8;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 5;
    localparam int LC_W    = 9;

    logic                      clk;
    logic                      rst;
    logic                      h264_reset;
    logic                      cnt_rst;
    logic                      start_cnt_i;
    logic                      coeff_valid_i;
    logic signed [COEFF_W-1:0] coeff_i;
    logic [1:0]                trailing_ones_cnt;
    logic                      trailing_ones_stop_cnt;
    logic                      blk_done_i;
    logic [LC_W-1:0]           level_code_o;
    logic                      level_valid_o;
    logic                      level_last_o;
    logic                      level_ready_i;
    logic [CNT_W-1:0]          level_code_cnt;
    logic                      done_o;
    logic                      ovf_o;
    logic                      err_o;

    int checks;
    int errors;

    logic [LC_W:0] sb_q [$];
    logic [LC_W:0] exp_beat;

    logic rdy_pat  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   code_pat [6] = '{8, 8, 5, 5, 5, 2};
    logic last_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    level_code_buffer #(
        .COEFF_W(COEFF_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .LC_W(LC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .h264_reset(h264_reset),
        .cnt_rst(cnt_rst),
        .start_cnt_i(start_cnt_i),
        .coeff_valid_i(coeff_valid_i),
        .coeff_i(coeff_i),
        .trailing_ones_cnt(trailing_ones_cnt),
        .trailing_ones_stop_cnt(trailing_ones_stop_cnt),
        .blk_done_i(blk_done_i),
        .level_code_o(level_code_o),
        .level_valid_o(level_valid_o),
        .level_last_o(level_last_o),
        .level_ready_i(level_ready_i),
        .level_code_cnt(level_code_cnt),
        .done_o(done_o),
        .ovf_o(ovf_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int code, input logic last);
        sb_q.push_back({LC_W'(code), last});
    endtask

    // One input cycle; valid and blk_done are single-cycle.
    task automatic send(input logic vld, input int c, input int toc, input logic stop, input logic blk);
        coeff_valid_i          = vld;
        coeff_i                = COEFF_W'(c);
        trailing_ones_cnt      = 2'(toc);
        trailing_ones_stop_cnt = stop;
        blk_done_i             = blk;
        @(posedge clk);
        #1;
        coeff_valid_i = 1'b0;
        blk_done_i    = 1'b0;
    endtask

    // Counts negedges until done_o is seen, bounded.
    task automatic wait_done(input string name, input int exp_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < 60);
        check(name, 32'(n), 32'(exp_cycles));
    endtask

    task automatic pulse_cnt_rst();
        cnt_rst = 1'b1;
        @(posedge clk);
        #1;
        cnt_rst = 1'b0;
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (level_valid_o && level_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got code %0d, expected no beat", level_code_o);
            end else begin
                exp_beat = sb_q.pop_front();
                check("beat_code", 32'(level_code_o), 32'(exp_beat[LC_W:1]));
                check("beat_last", 32'(level_last_o), 32'(exp_beat[0]));
            end
        end
    end

    initial begin
        int done_seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        h264_reset = 1'b0;
        cnt_rst = 1'b0;
        start_cnt_i = 1'b1;
        coeff_valid_i = 1'b0;
        coeff_i = '0;
        trailing_ones_cnt = 2'd0;
        trailing_ones_stop_cnt = 1'b0;
        blk_done_i = 1'b0;
        level_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(level_valid_o), 32'd0);
        check("rst_last", 32'(level_last_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_cnt", 32'(level_code_cnt), 32'd0);
        check("rst_code", 32'(level_code_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        // 1: three trailing ones, coeffs 5,-3,0,2 (write + blk_done together)
        push(8, 1'b0); push(5, 1'b0); push(2, 1'b1);
        send(1'b1, 5, 3, 1'b0, 1'b0);
        send(1'b1, -3, 3, 1'b0, 1'b0);
        send(1'b1, 0, 3, 1'b0, 1'b0);
        send(1'b1, 2, 3, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_cnt", 32'(level_code_cnt), 32'd3);
        wait_done("t1_done_lat", 3);
        @(negedge clk);
        check("t1_done_pulse", 32'(done_o), 32'd0);
        check("t1_cnt_clr", 32'(level_code_cnt), 32'd0);

        // 2: TrailingOnes=1, first level adjusted
        push(2, 1'b0); push(3, 1'b1);
        send(1'b1, 3, 1, 1'b1, 1'b0);
        send(1'b1, -2, 1, 1'b1, 1'b1);
        wait_done("t2_done_lat", 3);
        check("t2_err", 32'(err_o), 32'd0);
        @(negedge clk);

        // 3: TrailingOnes=0, first level -1 -> unadjusted, err set
        push(1, 1'b0); push(6, 1'b1);
        send(1'b1, -1, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_err_set", 32'(err_o), 32'd1);
        send(1'b1, 4, 0, 1'b1, 1'b1);
        wait_done("t3_done_lat", 3);
        @(negedge clk);
        check("t3_err_sticky", 32'(err_o), 32'd1);
        pulse_cnt_rst();
        @(negedge clk);
        check("t3_err_clr", 32'(err_o), 32'd0);

        // 4: back-pressure pattern 0,1,0,0,1,1
        push(8, 1'b0); push(5, 1'b0); push(2, 1'b1);
        send(1'b1, 5, 3, 1'b0, 1'b0);
        send(1'b1, -3, 3, 1'b0, 1'b0);
        level_ready_i = 1'b0;
        send(1'b1, 2, 3, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            level_ready_i = rdy_pat[i];
            @(negedge clk);
            check("t4_hold_code", 32'(level_code_o), 32'(code_pat[i]));
            check("t4_hold_last", 32'(level_last_o), 32'(last_pat[i]));
            @(posedge clk);
            #1;
        end
        level_ready_i = 1'b1;
        @(negedge clk);
        check("t4_done", 32'(done_o), 32'd1);
        @(negedge clk);

        // 5: overflow with 17 writes, then empty block
        for (int k = 1; k <= 16; k++) begin
            push(2 * k - 2, (k == 16));
        end
        for (int k = 1; k <= 17; k++) begin
            send(1'b1, k, 3, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("t5_cnt_full", 32'(level_code_cnt), 32'd16);
        check("t5_ovf", 32'(ovf_o), 32'd1);
        send(1'b0, 0, 3, 1'b0, 1'b1);
        wait_done("t5_done_lat", 17);
        @(negedge clk);
        check("t5_cnt_clr", 32'(level_code_cnt), 32'd0);
        check("t5_ovf_sticky", 32'(ovf_o), 32'd1);
        send(1'b0, 0, 3, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_empty_done", 32'(done_o), 32'd1);
        check("t5_empty_valid", 32'(level_valid_o), 32'd0);
        @(negedge clk);
        check("t5_empty_done_end", 32'(done_o), 32'd0);
        h264_reset = 1'b1;
        @(posedge clk);
        #1;
        h264_reset = 1'b0;
        @(negedge clk);
        check("t5_ovf_clr", 32'(ovf_o), 32'd0);

        // 6a: cnt_rst after the first drain beat aborts without done
        push(8, 1'b0);
        send(1'b1, 5, 3, 1'b0, 1'b0);
        send(1'b1, -3, 3, 1'b0, 1'b0);
        send(1'b1, 2, 3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        cnt_rst = 1'b1;
        level_ready_i = 1'b0;
        @(posedge clk);
        #1;
        cnt_rst = 1'b0;
        @(negedge clk);
        check("t6_abort_valid", 32'(level_valid_o), 32'd0);
        check("t6_abort_cnt", 32'(level_code_cnt), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o) done_seen++;
            @(negedge clk);
        end
        check("t6_abort_no_done", 32'(done_seen), 32'd0);
        level_ready_i = 1'b1;

        // 6b: rst mid-block clears everything
        send(1'b1, 1, 0, 1'b1, 1'b0);
        send(1'b1, 5, 3, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_pre_err", 32'(err_o), 32'd1);
        check("t6_pre_cnt", 32'(level_code_cnt), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_cnt", 32'(level_code_cnt), 32'd0);
        check("t6_rst_err", 32'(err_o), 32'd0);
        check("t6_rst_valid", 32'(level_valid_o), 32'd0);
        check("t6_rst_code", 32'(level_code_o), 32'd0);
        check("t6_rst_last", 32'(level_last_o), 32'd0);
        check("t6_rst_done", 32'(done_o), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_code_buffer.md
Name: level_code_buffer

Overview:
- Parametrised successor to the CAVLC level collector. It captures the non-trailing-one non-zero coefficients of one 4x4/2x2 block, in scan order.
- Each level is converted on write into its CAVLC levelCode, including the first-level adjustment when TrailingOnes<3.
- After the block scan, the stored codes are drained to the level-prefix/suffix encoder over a valid/ready stream.
- Sits between the coefficient scanner / trailing-ones counter and the level VLC stage.

Parameters:
- COEFF_W, 8, signed coefficient width (two's complement).
- DEPTH, 16, maximum stored levels per block (16 luma 4x4, 4 chroma DC, 15 AC).
- CNT_W, $clog2(DEPTH+1), width of count outputs.
- LC_W, COEFF_W+1, unsigned levelCode width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- h264_reset  in  1  synchronous frame/stream clear, same effect as rst.
- cnt_rst  in  1  synchronous per-block clear.
- start_cnt_i  in  1  scan window active.
- coeff_valid_i  in  1  coeff_i valid this cycle.
- coeff_i  in  COEFF_W  signed coefficient, reverse-zigzag order.
- trailing_ones_cnt  in  2  current TrailingOnes count (0..3).
- trailing_ones_stop_cnt  in  1  trailing-ones search finished.
- blk_done_i  in  1  pulse: last coefficient of block presented.
- level_code_o  out  LC_W  levelCode at head of buffer.
- level_valid_o  out  1  level_code_o valid.
- level_last_o  out  1  current beat is the last stored level.
- level_ready_i  in  1  downstream accepts beat.
- level_code_cnt  out  CNT_W  number of levels stored.
- done_o  out  1  one-cycle pulse: block fully drained.
- ovf_o  out  1  sticky: write attempted while full.
- err_o  out  1  sticky: first level was ±1 while TrailingOnes<3.

Behaviour:
- Reset and clear priority: rst > h264_reset > cnt_rst. All three are synchronous.
  - rst and h264_reset clear: state=COLLECT, wr count=0, rd_ptr=0, all storage=0, ovf_o=0, err_o=0.
  - cnt_rst does the same, except that ovf_o and err_o are also cleared only by cnt_rst/rst/h264_reset (any of the three).
  - Reset values of outputs: level_valid_o=0, level_last_o=0, done_o=0, level_code_cnt=0, level_code_o=0.
- States: COLLECT, DRAIN, DONE.
- COLLECT, write condition: coeff_valid_i & start_cnt_i & (trailing_ones_cnt==3 | trailing_ones_stop_cnt) & coeff_i!=0.
  - On a write, store at index level_code_cnt, then increment the count the next edge.
  - levelCode for level L, computed at width LC_W:
    - L>0: 2L-2.
    - L<0: -2L-1.
    - Example: L=-128 at 8 bits gives 255.
  - First-level adjustment: applies to the first write of a block (count==0) when trailing_ones_cnt<3. Stored code = levelCode-2.
  - If |L|==1 in that case, the adjustment would underflow. Store the unadjusted code and set err_o.
  - Write while count==DEPTH: data is dropped, count holds, ovf_o is set.
- COLLECT, blk_done_i:
  - count>0: next state DRAIN, rd_ptr=0.
  - count==0: next state DONE.
  - If a write and blk_done_i occur in the same cycle, the write is taken first, and that element is included in DRAIN.
- DRAIN:
  - level_valid_o=1.
  - level_code_o = mem[rd_ptr], driven from registered rd_ptr with no extra latency.
  - level_last_o = (rd_ptr==count-1).
  - Handshake on valid & ready: rd_ptr increments. On the last beat, next state is DONE.
  - Without ready, level_code_o and level_last_o hold stable.
  - Writes and blk_done_i are ignored in DRAIN.
  - level_code_cnt holds the block total throughout DRAIN.
- DONE (one cycle):
  - done_o=1.
  - Next cycle: state COLLECT, count=0, rd_ptr=0. ovf_o and err_o keep their values.
- cnt_rst asserted in DRAIN or DONE: abort to COLLECT next edge, valid=0, and no done_o pulse follows.
- level_code_cnt always reflects the registered write count.

Test Plan:
1. Three trailing ones, then coeffs 5,-3,0,2, blk_done, ready=1 -> stored 8,5,2; cnt=3; three beats with last on the 3rd; done_o one cycle after the last beat, then cnt=0.
2. Stop with trailing_ones_cnt=1, coeffs 3,-2 -> codes 2 (4-2 adjusted), 3; err_o=0.
3. trailing_ones_cnt=0, first coeff -1 -> stored 1 (unadjusted), err_o=1 until cnt_rst.
4. Drain of 8,5,2 with ready pattern 0,1,0,0,1,1 -> beat 8 held until cycle 2; 5 held two cycles; 2 accepted at cycle 6; last only on 2.
5. DEPTH=16, 17 non-zero writes -> cnt=16, ovf_o=1, 17th value absent from drain; blk_done with cnt=0 -> done_o next cycle, level_valid_o never high.
6. cnt_rst after first drain beat -> level_valid_o=0 next cycle, cnt=0, no done_o; rst in COLLECT mid-block -> all outputs 0 next cycle.
